// File: rtl/ctrl_seq.sv
// ctrl_seq: opcode-to-control-strobe sequencer.
// Each accepted opcode produces one or more registered control beats.
// CALL/RET take two beats and sprite loads take SPR_WORDS beats. While a
// multi-beat sequence is in flight, new opcodes are refused.
module ctrl_seq #(
    parameter int OPW       = 6,
    parameter int SPR_WORDS = 4,
    parameter int IDXW      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [OPW-1:0]  opcode,
    output logic            in_ready,
    input  logic            hold,
    input  logic            flush,
    output logic            out_valid,
    output logic            call,
    output logic            ret,
    output logic            branch,
    output logic            mem_to_reg,
    output logic            mem_src,
    output logic            reg_write,
    output logic            mem_write,
    output logic            mem_read,
    output logic            oam_write,
    output logic [1:0]      alu_src,
    output logic [IDXW-1:0] word_idx,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, SEQ2, BURST} state_t;

    typedef struct packed {
        logic            call;
        logic            ret;
        logic            branch;
        logic            mem_to_reg;
        logic            mem_src;
        logic            reg_write;
        logic            mem_write;
        logic            mem_read;
        logic            oam_write;
        logic [1:0]      alu_src;
        logic [IDXW-1:0] word_idx;
    } beat_t;

    // A burst leaves BURST when the penultimate beat is on the output,
    // so the final beat is presented with the FSM already back in IDLE.
    localparam logic [IDXW-1:0] PEN_IDX = IDXW'(SPR_WORDS - 2);

    state_t     state_q, state_d, dec_state;
    beat_t      beat_q, beat_d, dec;
    logic       vld_q, vld_d;
    logic       stall, accept;
    logic [2:0] cls;
    logic [3:0] sub;

    assign cls    = opcode[OPW-1:OPW-3];
    assign sub    = opcode[3:0];
    assign stall  = vld_q && hold;
    assign accept = in_valid && in_ready;

    assign in_ready = !rst && (state_q == IDLE) && !stall && !flush;
    assign busy     = (state_q != IDLE);

    // First beat and follow-on state for the opcode currently offered
    always_comb begin
        dec       = '0;
        dec_state = IDLE;
        if (cls[2]) begin
            dec.reg_write = 1'b1;
            dec.alu_src   = opcode[1] ? (opcode[2] ? 2'b10 : 2'b00)
                                      : (opcode[0] ? 2'b01 : 2'b00);
        end else begin
            case (cls[1:0])
                2'b00: begin
                    dec.branch  = 1'b1;
                    dec.alu_src = 2'b01;
                end
                2'b01: begin
                    dec_state = SEQ2;
                    if (!opcode[0]) begin
                        dec.call      = 1'b1;
                        dec.mem_write = 1'b1;
                    end else begin
                        dec.ret      = 1'b1;
                        dec.mem_read = 1'b1;
                        dec.mem_src  = 1'b1;
                    end
                end
                2'b10: begin
                    dec.alu_src = 2'b01;
                    if (!opcode[2]) begin
                        dec.mem_read   = 1'b1;
                        dec.reg_write  = 1'b1;
                        dec.mem_to_reg = !opcode[0];
                    end else begin
                        dec.mem_write = 1'b1;
                        dec.mem_src   = 1'b1;
                        dec.reg_write = opcode[1];
                    end
                end
                default: begin
                    dec.oam_write = 1'b1;
                    if (sub != 4'hF) begin
                        dec_state    = BURST;
                        dec.mem_read = 1'b1;
                        dec.mem_src  = 1'b1;
                        dec.alu_src  = 2'b11;
                    end
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: flush wins, a held beat freezes, otherwise one beat per cycle
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else if (!stall) begin
            case (state_q)
                IDLE:    if (accept) state_d = dec_state;
                SEQ2:    state_d = IDLE;
                BURST:   if (beat_q.word_idx == PEN_IDX) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next output beat; an invalid beat is all zeros
    always_comb begin
        beat_d = '0;
        vld_d  = 1'b0;
        if (flush) begin
            beat_d = '0;
            vld_d  = 1'b0;
        end else if (stall) begin
            beat_d = beat_q;
            vld_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        beat_d = dec;
                        vld_d  = 1'b1;
                    end
                end
                SEQ2: begin
                    vld_d             = 1'b1;
                    beat_d.call       = beat_q.call;
                    beat_d.ret        = beat_q.ret;
                    beat_d.mem_to_reg = beat_q.ret;
                    beat_d.reg_write  = 1'b1;
                    beat_d.word_idx   = IDXW'(1);
                end
                BURST: begin
                    vld_d            = 1'b1;
                    beat_d.oam_write = 1'b1;
                    beat_d.mem_read  = 1'b1;
                    beat_d.mem_src   = 1'b1;
                    beat_d.alu_src   = 2'b11;
                    beat_d.word_idx  = beat_q.word_idx + IDXW'(1);
                end
                default: ;
            endcase
        end
    end

    // Output beat register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            beat_q <= '0;
        end else begin
            vld_q  <= vld_d;
            beat_q <= beat_d;
        end
    end

    assign out_valid  = vld_q;
    assign call       = beat_q.call;
    assign ret        = beat_q.ret;
    assign branch     = beat_q.branch;
    assign mem_to_reg = beat_q.mem_to_reg;
    assign mem_src    = beat_q.mem_src;
    assign reg_write  = beat_q.reg_write;
    assign mem_write  = beat_q.mem_write;
    assign mem_read   = beat_q.mem_read;
    assign oam_write  = beat_q.oam_write;
    assign alu_src    = beat_q.alu_src;
    assign word_idx   = beat_q.word_idx;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed and random checks of ctrl_seq against a beat-queue model.
module tb_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [5:0] opcode = '0;
    logic       hold = 1'b0;
    logic       flush = 1'b0;
    logic       in_ready, out_valid, call, ret, branch, mem_to_reg, mem_src;
    logic       reg_write, mem_write, mem_read, oam_write, busy;
    logic [1:0] alu_src;
    logic [3:0] word_idx;

    ctrl_seq #(.OPW(6), .SPR_WORDS(4), .IDXW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
        .in_ready(in_ready), .hold(hold), .flush(flush), .out_valid(out_valid),
        .call(call), .ret(ret), .branch(branch), .mem_to_reg(mem_to_reg),
        .mem_src(mem_src), .reg_write(reg_write), .mem_write(mem_write),
        .mem_read(mem_read), .oam_write(oam_write), .alu_src(alu_src),
        .word_idx(word_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    // Beat encoding used by the model: strobes, alu_src[5:4], word_idx[3:0]
    localparam logic [14:0] B_CALL = 15'h4000, B_RET = 15'h2000, B_BR  = 15'h1000;
    localparam logic [14:0] B_M2R  = 15'h0800, B_MSRC = 15'h0400, B_RW = 15'h0200;
    localparam logic [14:0] B_MW   = 15'h0100, B_MR  = 15'h0080, B_OAM = 15'h0040;
    localparam logic [14:0] A1 = 15'h0010, A2 = 15'h0020, A3 = 15'h0030;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model: beat on the output register plus beats still to come
    logic        m_v   = 1'b0;
    logic [14:0] m_cur = '0;
    logic [14:0] pend[$];

    function automatic logic [14:0] obs();
        return {call, ret, branch, mem_to_reg, mem_src, reg_write, mem_write,
                mem_read, oam_write, alu_src, word_idx};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    // All beats an opcode produces, in presentation order
    task automatic expand(input logic [5:0] op);
        logic [2:0]  c;
        logic [14:0] a;
        c = op[5:3];
        if (c >= 3'd4) begin
            a = op[1] ? (op[2] ? A2 : 15'h0) : (op[0] ? A1 : 15'h0);
            pend.push_back(B_RW | a);
        end else if (c == 3'd0) begin
            pend.push_back(B_BR | A1);
        end else if (c == 3'd1) begin
            if (op[0] == 1'b0) begin
                pend.push_back(B_CALL | B_MW);
                pend.push_back(B_CALL | B_RW | 15'd1);
            end else begin
                pend.push_back(B_RET | B_MR | B_MSRC);
                pend.push_back(B_RET | B_RW | B_M2R | 15'd1);
            end
        end else if (c == 3'd2) begin
            if (op[2] == 1'b0) pend.push_back(B_MR | B_RW | (op[0] ? 15'h0 : B_M2R) | A1);
            else               pend.push_back(B_MW | B_MSRC | (op[1] ? B_RW : 15'h0) | A1);
        end else begin
            if (op[3:0] != 4'hF)
                for (int i = 0; i < 4; i++) pend.push_back(B_OAM | B_MR | B_MSRC | A3 | 15'(i));
            else
                pend.push_back(B_OAM);
        end
    endtask

    // One clock: drive, compare pre-edge view with the model, advance model
    task automatic tick(input logic iv, input logic [5:0] op, input logic hd, input logic fl);
        logic rdy;
        in_valid = iv; opcode = op; hold = hd; flush = fl;
        #1;
        rdy = (pend.size() == 0) && !(m_v && hd) && !fl;
        check("in_ready", in_ready, rdy);
        check("out_valid", out_valid, m_v);
        check("beat", obs(), m_v ? m_cur : 15'h0);
        check("busy", busy, pend.size() != 0);
        @(posedge clk);
        if (fl) begin
            m_v = 1'b0; m_cur = '0; pend.delete();
        end else if (m_v && hd) begin
            m_v = m_v;
        end else if (pend.size() != 0) begin
            m_cur = pend.pop_front(); m_v = 1'b1;
        end else if (iv && rdy) begin
            expand(op);
            m_cur = pend.pop_front(); m_v = 1'b1;
        end else begin
            m_v = 1'b0; m_cur = '0;
        end
        #1;
    endtask

    initial begin
        logic [3:0] exp_idx [7];
        exp_idx = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3};

        // Reset state
        #2;
        check("rst_beat", obs(), 15'h0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ADD then ADDI back-to-back
        tick(1'b1, 6'b100000, 1'b0, 1'b0);
        check("add_beat", obs(), B_RW);
        check("add_ready", in_ready, 1'b1);
        tick(1'b1, 6'b100001, 1'b0, 1'b0);
        check("addi_beat", obs(), B_RW | A1);
        tick(1'b0, 6'b0, 1'b0, 1'b0);
        check("idle_valid", out_valid, 1'b0);

        // CALL: two beats, one refused cycle
        tick(1'b1, 6'b001000, 1'b0, 1'b0);
        check("call_b0", obs(), B_CALL | B_MW);
        check("call_ready0", in_ready, 1'b0);
        tick(1'b1, 6'b100000, 1'b0, 1'b0);
        check("call_b1", obs(), B_CALL | B_RW | 15'd1);
        check("call_ready1", in_ready, 1'b1);
        tick(1'b0, 6'b0, 1'b0, 1'b0);
        tick(1'b0, 6'b0, 1'b0, 1'b0);

        // Sprite load with a 3-cycle hold on beat 2
        tick(1'b1, 6'b011000, 1'b0, 1'b0);
        check("spr_idx0", word_idx, exp_idx[0]);
        tick(1'b0, 6'b0, 1'b0, 1'b0);
        check("spr_idx1", word_idx, exp_idx[1]);
        tick(1'b0, 6'b0, 1'b0, 1'b0);
        for (int i = 2; i < 5; i++) begin
            check("spr_idx_hold", word_idx, exp_idx[i]);
            tick(1'b0, 6'b0, 1'b1, 1'b0);
        end
        check("spr_idx5", word_idx, exp_idx[5]);
        check("spr_oam", oam_write, 1'b1);
        tick(1'b0, 6'b0, 1'b0, 1'b0);
        check("spr_idx6", word_idx, exp_idx[6]);
        check("spr_last_busy", busy, 1'b0);
        tick(1'b0, 6'b0, 1'b0, 1'b0);
        check("spr_done", out_valid, 1'b0);

        // Flush on beat 1 of a burst
        tick(1'b1, 6'b011000, 1'b0, 1'b0);
        tick(1'b0, 6'b0, 1'b0, 1'b0);
        check("fl_idx1", word_idx, 4'd1);
        tick(1'b1, 6'b100000, 1'b1, 1'b1);
        check("fl_valid", out_valid, 1'b0);
        check("fl_busy", busy, 1'b0);
        check("fl_idx", word_idx, 4'd0);
        for (int i = 0; i < 3; i++) tick(1'b0, 6'b0, 1'b0, 1'b0);

        // Reset pulse during RET beat 0
        tick(1'b1, 6'b001001, 1'b0, 1'b0);
        check("ret_b0", obs(), B_RET | B_MR | B_MSRC);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_beat", obs(), 15'h0);
        check("arst_valid", out_valid, 1'b0);
        check("arst_ready", in_ready, 1'b0);
        check("arst_busy", busy, 1'b0);
        m_v = 1'b0; m_cur = '0; pend.delete();
        #1;
        rst = 1'b0;
        tick(1'b0, 6'b0, 1'b0, 1'b0);
        tick(1'b0, 6'b0, 1'b0, 1'b0);
        check("ret_no_b1", out_valid, 1'b0);

        // Sprite commit then store
        tick(1'b1, 6'b011111, 1'b0, 1'b0);
        check("commit", obs(), B_OAM);
        tick(1'b1, 6'b010110, 1'b0, 1'b0);
        check("store", obs(), B_MW | B_MSRC | B_RW | A1);
        tick(1'b0, 6'b0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++)
            tick(1'($urandom_range(0, 1)), 6'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
